// File: rtl/execute_cycle_if.sv
// EX-stage bundle: decode-side E inputs, forwarding sources, branch results and the EX/MEM *M outputs.
// master = upstream/pipeline side, slave = execute_cycle.
interface execute_cycle_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6
);
    logic                  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, FlushE;
    logic [2:0]            ALUControlE;
    logic [1:0]            ForwardA_E, ForwardB_E;
    logic [DATA_W-1:0]     RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [REG_ADDR_W-1:0] RD_E;
    logic                  PCSrcE, StallE;
    logic [DATA_W-1:0]     PCTargetE;
    logic                  RegWriteM, MemWriteM, ResultSrcM;
    logic [REG_ADDR_W-1:0] RD_M;
    logic [DATA_W-1:0]     PCPlus4M, WriteDataM, ALU_ResultM;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, FlushE, ALUControlE,
               ForwardA_E, ForwardB_E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E,
        input  PCSrcE, StallE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, FlushE, ALUControlE,
               ForwardA_E, ForwardB_E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E,
        output PCSrcE, StallE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, beq resolution and the EX/MEM register; latency 1 edge.
// EXECUTE_MUL_EN adds an iterative shift-add multiplier that holds StallE for DATA_W cycles.
module execute_cycle #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    execute_cycle_if.slave  ex
);
    logic [DATA_W-1:0]     src_a, src_b_fwd, src_b, alu_y, diff;
    logic                  zero, stall, bubble;
    logic                  reg_write_q, mem_write_q, result_src_q;
    logic                  reg_write_d, mem_write_d, result_src_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     pcplus4_q, pcplus4_d, write_data_q, write_data_d, alu_result_q, alu_result_d;

    // Code 11 on a forward select falls back to the register file operand.
    always_comb begin
        case (ex.ForwardA_E)
            2'b01:   src_a = ex.ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = ex.RD1_E;
        endcase
        case (ex.ForwardB_E)
            2'b01:   src_b_fwd = ex.ResultW;
            2'b10:   src_b_fwd = alu_result_q;
            default: src_b_fwd = ex.RD2_E;
        endcase
        src_b = ex.ALUSrcE ? ex.Imm_Ext_E : src_b_fwd;
    end

    always_comb begin
        case (ex.ALUControlE)
            3'b000:  alu_y = src_a + src_b;
            3'b001:  alu_y = src_a - src_b;
            3'b010:  alu_y = src_a & src_b;
            3'b011:  alu_y = src_a | src_b;
            3'b100:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b101:  alu_y = src_a ^ src_b;
            3'b110:  alu_y = src_a << src_b[4:0];
            default: alu_y = '0;
        endcase
    end

    assign diff         = src_a - src_b;
    assign zero         = (diff == '0);
    assign ex.PCSrcE    = ex.BranchE & zero & ~ex.FlushE;
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
    assign ex.StallE    = stall;

`ifdef EXECUTE_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, wd_q, wd_d, step_sum;

    assign step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        stall        = 1'b0;
        bubble       = 1'b0;
        reg_write_d  = ex.RegWriteE;
        mem_write_d  = ex.MemWriteE;
        result_src_d = ex.ResultSrcE;
        rd_d         = ex.RD_E;
        pcplus4_d    = ex.PCPlus4E;
        write_data_d = src_b_fwd;
        alu_result_d = alu_y;
`ifdef EXECUTE_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        wd_d     = wd_q;
        case (state_q)
            S_IDLE: begin
                if (ex.ALUControlE == 3'b111) begin
                    stall    = 1'b1;
                    bubble   = 1'b1;
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    prod_d   = '0;
                    wd_d     = src_b_fwd;
                end
            end
            default: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                prod_d   = step_sum;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == MUL_LAST) begin
                    // E-side controls are still held by upstream on the completion cycle.
                    state_d      = S_IDLE;
                    alu_result_d = step_sum;
                    write_data_d = wd_q;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
        endcase
        if (ex.FlushE) begin
            state_d = S_IDLE;
            stall   = 1'b0;
        end
`endif
        if (ex.FlushE) bubble = 1'b1;
        if (bubble) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = 1'b0;
            rd_d         = '0;
            pcplus4_d    = '0;
            write_data_d = '0;
            alu_result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pcplus4_q    <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pcplus4_q    <= pcplus4_d;
            write_data_q <= write_data_d;
            alu_result_q <= alu_result_d;
        end
    end

`ifdef EXECUTE_MUL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            wd_q     <= wd_d;
        end
    end
`endif

    assign ex.RegWriteM   = reg_write_q;
    assign ex.MemWriteM   = mem_write_q;
    assign ex.ResultSrcM  = result_src_q;
    assign ex.RD_M        = rd_q;
    assign ex.PCPlus4M    = pcplus4_q;
    assign ex.WriteDataM  = write_data_q;
    assign ex.ALU_ResultM = alu_result_q;
endmodule
